// File: rtl/restoring_div_pkg.sv
// Shared types and constants for the sequential unsigned restoring divider.
package restoring_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_DVD,
    ST_LOAD_DVS,
    ST_SHIFT,
    ST_SUB,
    ST_OUT_Q,
    ST_OUT_R
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/restoring_div_cu.sv
// Control unit: FSM, iteration counter and datapath strobes for restoring_div.
// Optional divide-by-zero short cut enabled by the DIV_ZERO_DETECT_EN macro.
module restoring_div_cu
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic dvs_zero_i,
  output logic ld_dvd_o,
  output logic ld_dvs_o,
  output logic dz_load_o,
  output logic shift_o,
  output logic sub_o,
  output logic sel_q_o,
  output logic sel_r_o,
  output logic done_o,
  output logic div_zero_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_dvd_o  = 1'b0;
    ld_dvs_o  = 1'b0;
    dz_load_o = 1'b0;
    shift_o   = 1'b0;
    sub_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_LOAD_DVD;
      end
      ST_LOAD_DVD: begin
        ld_dvd_o = 1'b1;
        cnt_d    = '0;
        state_d  = ST_LOAD_DVS;
      end
      ST_LOAD_DVS: begin
        ld_dvs_o = 1'b1;
        state_d  = ST_SHIFT;
`ifdef DIV_ZERO_DETECT_EN
        if (dvs_zero_i) begin
          dz_load_o = 1'b1;
          state_d   = ST_OUT_Q;
        end
`endif
      end
      ST_SHIFT: begin
        shift_o = 1'b1;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        sub_o   = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? ST_OUT_Q : ST_SHIFT;
      end
      ST_OUT_Q: state_d = ST_OUT_R;
      ST_OUT_R: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign sel_q_o = (state_q == ST_OUT_Q);
  assign sel_r_o = (state_q == ST_OUT_R);
  assign done_o  = (state_q == ST_OUT_R);

`ifdef DIV_ZERO_DETECT_EN
  // Flag is captured once per operation at divisor load and only shown during output.
  logic dz_q;

  always_ff @(posedge clk) begin
    if (rst)           dz_q <= 1'b0;
    else if (ld_dvs_o) dz_q <= dvs_zero_i;
  end

  assign div_zero_o = dz_q & (sel_q_o | sel_r_o);
`else
  logic unused_dvs_zero;
  assign unused_dvs_zero = dvs_zero_i;
  assign div_zero_o      = 1'b0;
`endif

endmodule

// File: rtl/restoring_div.sv
// Sequential unsigned restoring divider: A/Q/M datapath driven by restoring_div_cu.
// Build option DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to the output.
module restoring_div
  import restoring_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] inbus,
  output logic             done,
  output logic [WIDTH-1:0] outbus,
  output logic             div_zero
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   diff;

  logic ld_dvd, ld_dvs, dz_load, shift_en, sub_en, sel_q, sel_r;

  restoring_div_cu #(.WIDTH(WIDTH)) u_cu (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .dvs_zero_i (inbus == '0),
    .ld_dvd_o   (ld_dvd),
    .ld_dvs_o   (ld_dvs),
    .dz_load_o  (dz_load),
    .shift_o    (shift_en),
    .sub_o      (sub_en),
    .sel_q_o    (sel_q),
    .sel_r_o    (sel_r),
    .done_o     (done),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
    end
  end

  assign diff = a_q - {1'b0, m_q};

  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    if (ld_dvd) begin
      q_d = inbus;
      a_d = '0;
    end
    if (ld_dvs) begin
      m_d = inbus;
      // Zero divisor: the dividend still sitting in Q becomes the remainder.
      if (dz_load) begin
        q_d = '1;
        a_d = {1'b0, q_q};
      end
    end
    // A < M after every SUB, so A's MSB is always clear and can be dropped here.
    if (shift_en) {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
    if (sub_en && !diff[WIDTH]) begin
      a_d = diff;
      q_d = {q_q[WIDTH-1:1], 1'b1};
    end
  end

  always_comb begin
    outbus = '0;
    if (sel_q)      outbus = q_q;
    else if (sel_r) outbus = a_q[WIDTH-1:0];
  end

endmodule

// File: tb/tb_restoring_div.sv
// Directed and randomized bench for restoring_div; honours DIV_ZERO_DETECT_EN when defined.
module tb_restoring_div;

  localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] inbus = '0;
  logic         done;
  logic [W-1:0] outbus;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  restoring_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .inbus    (inbus),
    .done     (done),
    .outbus   (outbus),
    .div_zero (div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle (cycle 0); returns in cycle 3.
  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    inbus  = dvd;
    tick();
    inbus  = dvs;
    tick();
    inbus  = '0;
  endtask

  // Runs the 2*W iteration cycles, optionally with junk on enable/inbus.
  task automatic iterate(input bit noisy);
    for (int i = 0; i < 2 * W; i++) begin
      if (noisy) begin
        enable = 1'($urandom_range(0, 1));
        inbus  = W'($urandom);
      end
      tick();
    end
    enable = 1'b0;
    inbus  = '0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    inbus  = 8'hAA;
    tick();
    tick();
    n_checks++;
    if (outbus !== 8'h00) begin n_fail++; $display("FAIL reset_outbus got=%h want=00", outbus); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++;
    if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
    rst    = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++;
      if ({done, div_zero, outbus} !== '0) begin
        n_fail++;
        $display("FAIL idle_quiet cyc=%0d got done=%b dz=%b out=%h want 0/0/00", i, done, div_zero, outbus);
      end
    end
  endtask

  task automatic test_basic();
    start_op(8'd100, 8'd7);
    iterate(1'b0);
    n_checks++;
    if (outbus !== 8'h0E || done !== 1'b0 || div_zero !== 1'b0) begin
      n_fail++; $display("FAIL basic_q got out=%h done=%b dz=%b want 0e/0/0", outbus, done, div_zero);
    end
    tick();
    n_checks++;
    if (outbus !== 8'h02 || done !== 1'b1 || div_zero !== 1'b0) begin
      n_fail++; $display("FAIL basic_r got out=%h done=%b dz=%b want 02/1/0", outbus, done, div_zero);
    end
    tick();
    n_checks++;
    if (outbus !== 8'h00 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_after got out=%h done=%b want 00/0", outbus, done);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] dvd [2] = '{8'd255, 8'd5};
    logic [W-1:0] dvs [2] = '{8'd1,   8'd9};
    logic [W-1:0] eq  [2] = '{8'hFF,  8'h00};
    logic [W-1:0] er  [2] = '{8'h00,  8'h05};
    for (int k = 0; k < 2; k++) begin
      start_op(dvd[k], dvs[k]);
      iterate(k == 0);
      n_checks++;
      if (outbus !== eq[k]) begin n_fail++; $display("FAIL extreme_q%0d got=%h want=%h", k, outbus, eq[k]); end
      tick();
      n_checks++;
      if (outbus !== er[k] || done !== 1'b1) begin
        n_fail++; $display("FAIL extreme_r%0d got=%h done=%b want=%h/1", k, outbus, done, er[k]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    start_op(8'd200, 8'd0);
    if (!DZ) iterate(1'b0);
    n_checks++;
    if (outbus !== 8'hFF || done !== 1'b0 || div_zero !== DZ) begin
      n_fail++; $display("FAIL dz_q got out=%h done=%b dz=%b want ff/0/%b", outbus, done, div_zero, DZ);
    end
    tick();
    n_checks++;
    if (outbus !== 8'hC8 || done !== 1'b1 || div_zero !== DZ) begin
      n_fail++; $display("FAIL dz_r got out=%h done=%b dz=%b want c8/1/%b", outbus, done, div_zero, DZ);
    end
    tick();
    n_checks++;
    if (div_zero !== 1'b0 || outbus !== 8'h00) begin
      n_fail++; $display("FAIL dz_after got out=%h dz=%b want 00/0", outbus, div_zero);
    end
  endtask

  task automatic test_reset_mid();
    start_op(8'd100, 8'd7);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (outbus !== 8'h00 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got out=%h done=%b want 00/0", outbus, done);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++;
      if (outbus !== 8'h00 || done !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_idle cyc=%0d got out=%h done=%b want 00/0", i, outbus, done);
      end
    end
    start_op(8'd42, 8'd6);
    iterate(1'b0);
    n_checks++;
    if (outbus !== 8'h07) begin n_fail++; $display("FAIL rst_fresh_q got=%h want=07", outbus); end
    tick();
    n_checks++;
    if (outbus !== 8'h00 || done !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh_r got out=%h done=%b want 00/1", outbus, done);
    end
    tick();
    start_op(8'd13, 8'd4);
    iterate(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (outbus !== 8'h00 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_outq got out=%h done=%b want 00/0", outbus, done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    tick();
    inbus = 8'd100;
    tick();
    inbus = 8'd7;
    tick();
    for (int i = 0; i < 2 * W; i++) begin
      inbus = W'($urandom);
      tick();
    end
    n_checks++;
    if (outbus !== 8'h0E) begin n_fail++; $display("FAIL b2b_q1 got=%h want=0e", outbus); end
    tick();
    n_checks++;
    if (outbus !== 8'h02 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_r1 got out=%h done=%b want 02/1", outbus, done);
    end
    tick();
    tick();
    inbus = 8'd13;
    tick();
    inbus = 8'd4;
    tick();
    for (int i = 0; i < 2 * W; i++) begin
      inbus = W'($urandom);
      tick();
    end
    n_checks++;
    if (outbus !== 8'h03) begin n_fail++; $display("FAIL b2b_q2 got=%h want=03", outbus); end
    tick();
    n_checks++;
    if (outbus !== 8'h01 || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_r2 got out=%h done=%b want 01/1", outbus, done);
    end
    enable = 1'b0;
    inbus  = '0;
    tick();
    n_checks++;
    if (outbus !== 8'h00 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got out=%h done=%b want 00/0", outbus, done);
    end
  endtask

  task automatic test_random();
    int a, b, q, r;
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      start_op(W'(a), W'(b));
      for (int i = 0; i < 2 * W; i++) begin
        n_checks++;
        if ({done, div_zero, outbus} !== '0) begin
          n_fail++;
          $display("FAIL rnd_busy n=%0d cyc=%0d got done=%b dz=%b out=%h want 0/0/00", n, i, done, div_zero, outbus);
        end
        tick();
      end
      q = int'(outbus);
      n_checks++;
      if (outbus !== W'(a / b) || done !== 1'b0) begin
        n_fail++; $display("FAIL rnd_q %0d/%0d got=%h done=%b want=%h/0", a, b, outbus, done, W'(a / b));
      end
      tick();
      r = int'(outbus);
      n_checks++;
      if (outbus !== W'(a % b) || done !== 1'b1) begin
        n_fail++; $display("FAIL rnd_r %0d/%0d got=%h done=%b want=%h/1", a, b, outbus, done, W'(a % b));
      end
      n_checks++;
      if (q * b + r != a || r >= b) begin
        n_fail++; $display("FAIL rnd_identity %0d/%0d got q=%0d r=%0d", a, b, q, r);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/restoring_div.md
# restoring_div

Sequential unsigned restoring divider: the inverse-operation companion to the team's sequential Booth multiplier in the multiplication-devices library. It uses the same narrow byte-bus protocol. The dividend and then the divisor are loaded over `inbus` in consecutive cycles, and the quotient and then the remainder are returned on `outbus` in consecutive cycles. A control-unit FSM drives a datapath built from a partial-remainder register A, a quotient register Q and a divisor register M.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  start request; sampled only in IDLE.
- `inbus`  in  WIDTH  operand input: dividend in LOAD_DVD, divisor in LOAD_DVS.
- `done`  out  1  high only in the OUT_R cycle.
- `outbus`  out  WIDTH  quotient in OUT_Q, remainder in OUT_R, all-zero otherwise.
- `div_zero`  out  1  divide-by-zero flag; see Configuration.

## Operation
- Unsigned operands. A is WIDTH+1 bits, Q and M are WIDTH bits.
- FSM states: IDLE, LOAD_DVD, LOAD_DVS, SHIFT, SUB, OUT_Q, OUT_R.
- IDLE:
  - `enable`=1 moves to LOAD_DVD; otherwise stays in IDLE.
  - `inbus` is ignored.
- LOAD_DVD: Q <= `inbus`, A <= 0, iteration counter <= 0. Next state is LOAD_DVS.
- LOAD_DVS: M <= `inbus`. Next state is SHIFT.
- SHIFT: {A,Q} <= {A,Q} << 1 (Q[WIDTH-1] enters A[0], Q[0] <= 0). Next state is SUB.
- SUB:
  - Compute D = A - {1'b0,M} in WIDTH+1 bits.
  - If D[WIDTH]=0: A <= D and Q[0] <= 1.
  - Otherwise A is unchanged and Q[0] stays 0. Restoring is implicit; there is no separate restore cycle.
  - Counter increments.
  - After the WIDTH-th SUB, go to OUT_Q; otherwise go to SHIFT.
- OUT_Q: `outbus` = Q. Next state is OUT_R.
- OUT_R: `outbus` = A[WIDTH-1:0], `done`=1. Next state is IDLE.
- `enable` is ignored in every state except IDLE, and `inbus` is ignored outside the two LOAD states.
- Divisor 0 without detection gives quotient all-ones and remainder = dividend. This falls out of the algorithm and is specified behaviour.

## Timing
- Cycle numbering: cycle 0 is the IDLE cycle in which `enable`=1 is sampled.
- Cycle 1 is LOAD_DVD; the dividend must be on `inbus` then.
- Cycle 2 is LOAD_DVS; the divisor must be on `inbus` then.
- Cycles 3 .. 2*WIDTH+2 are the iterations (16 cycles for WIDTH=8).
- OUT_Q is cycle 2*WIDTH+3 (19 for WIDTH=8).
- OUT_R / `done` is cycle 2*WIDTH+4 (20 for WIDTH=8). The FSM is back in IDLE the following cycle.
- `done` is a one-cycle pulse. Back-to-back operation: `enable` held high restarts in the cycle after OUT_R.
- Outputs are registered or decoded from registered state only, with no combinational path from `inbus`/`enable` to the outputs.
- Reset values: FSM=IDLE, A=Q=M=0, counter=0, `done`=0, `outbus`=0, `div_zero`=0.
- `rst` asserted in any state, including mid-iteration or OUT_Q/OUT_R, forces the reset values at the next edge. `rst` takes priority over `enable`.

## Configuration
- Macro `DIV_ZERO_DETECT_EN`.
- With the macro defined:
  - In LOAD_DVS, if `inbus`==0, the FSM skips SHIFT/SUB and goes directly to OUT_Q with Q <= all-ones and A <= dividend.
  - `div_zero`=1 during OUT_Q and OUT_R.
  - OUT_Q is cycle 3 and OUT_R is cycle 4.
- Without the macro:
  - `div_zero` is tied to 0.
  - Divisor 0 runs the full 2*WIDTH iterations and produces the same output values.

## Structure
- Package `restoring_div_pkg` holds:
  - the FSM state enum typedef;
  - the default width constant;
  - the counter width constant, $clog2(WIDTH)+1.
- Sub-module `restoring_div_cu` holds the FSM, the iteration counter and the control decode: load/shift/sub strobes, output select, `done` and `div_zero`.
- The top level holds the A/Q/M registers, the WIDTH+1-bit subtractor and the output mux.

## Test plan
- 100 / 7 -> `outbus`=0x0E at cycle 19, `outbus`=0x02 with `done`=1 at cycle 20, `div_zero`=0.
- 255 / 1 -> quotient 0xFF, remainder 0x00. Then 5 / 9 -> quotient 0x00, remainder 0x05.
- 200 / 0:
  - without the macro -> 0xFF at cycle 19, 0xC8 at cycle 20, `div_zero`=0;
  - with `DIV_ZERO_DETECT_EN` -> 0xFF at cycle 3, 0xC8 at cycle 4, `div_zero`=1 in both cycles.
- `rst` pulsed at cycle 10 of an operation -> next cycle `done`=0, `outbus`=0, FSM in IDLE. A fresh 42 / 6 then yields 0x07 / 0x00 with nominal timing.
- `enable` held high continuously with inbus pairs 100/7 then 13/4 -> first result at cycles 19/20, second result (0x03 / 0x01) at cycles 40/41. `enable` toggling mid-operation has no effect.
- Random 1000 pairs with the divisor nonzero -> quotient*divisor+remainder == dividend and remainder < divisor; outputs stay 0 outside OUT_Q/OUT_R.
